// File: rtl/frame_cnt_sched.sv
// Snapshot/readout scheduler for a bank of frame counters: captures and clears all channels at once, then streams them out.
// Optional macro FRAME_CNT_SCHED_SUM_EN appends a saturating sum-of-channels word after the last channel.
module frame_cnt_sched #(
  parameter int CHANNELS     = 4,
  parameter int CNT_WIDTH    = 32,
  parameter int PERIOD_WIDTH = 24,
  parameter int OVF_WIDTH    = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          SW_REQ,
  input  logic [PERIOD_WIDTH-1:0]       PERIOD,
  input  logic [CHANNELS*CNT_WIDTH-1:0] CNT_IN,
  output logic [CHANNELS-1:0]           CNT_RST,
  output logic [CNT_WIDTH-1:0]          RD_DATA,
  output logic [$clog2(CHANNELS):0]     RD_CHAN,
  output logic                          RD_LAST,
  output logic                          RD_VLD,
  input  logic                          RD_DST_RDY,
  output logic                          BUSY,
  output logic                          DONE,
  output logic [OVF_WIDTH-1:0]          OVERRUN_CNT
);

  localparam int CHAN_W = $clog2(CHANNELS) + 1;
  localparam logic [CHAN_W-1:0] LAST_CH = CHAN_W'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, LATCH, SEND, FIN} state_t;

  state_t                        state, state_nxt;
  logic [PERIOD_WIDTH-1:0]       timer;
  logic [PERIOD_WIDTH-1:0]       period_m1;
  logic                          tmr_exp;
  logic                          req;
  logic                          pend;
  logic [OVF_WIDTH-1:0]          ovf_q;
  logic [CHANNELS*CNT_WIDTH-1:0] snap;
  logic [CNT_WIDTH-1:0]          rd_data;
  logic [CHAN_W-1:0]             rd_chan;
  logic [CHAN_W-1:0]             nxt_chan;
  logic                          rd_last;
  logic                          rd_vld;
  logic                          acc;

`ifdef FRAME_CNT_SCHED_SUM_EN
  localparam logic [CHAN_W-1:0] SUM_CH = CHAN_W'(CHANNELS);
  logic [CNT_WIDTH-1:0] sum_q;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH-1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction
`endif

  // Periodic timer: free-running while enabled, wraps on expiry (also when PERIOD drops below it)
  assign period_m1 = PERIOD - PERIOD_WIDTH'(1);
  assign tmr_exp   = (PERIOD != '0) && (timer >= period_m1);
  assign req       = SW_REQ | tmr_exp;
  assign acc       = rd_vld & RD_DST_RDY;
  assign nxt_chan  = rd_chan + CHAN_W'(1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      timer <= '0;
    end else if (PERIOD == '0 || tmr_exp) begin
      timer <= '0;
    end else begin
      timer <= timer + PERIOD_WIDTH'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req || pend) state_nxt = LATCH;
      LATCH:   state_nxt = SEND;
      SEND:    if (acc && rd_last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A request in IDLE is consumed by the launch; while busy only one is queued, the rest are counted
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend  <= 1'b0;
      ovf_q <= '0;
    end else if (state == IDLE) begin
      pend <= 1'b0;
    end else if (req) begin
      if (!pend) begin
        pend <= 1'b1;
      end else if (ovf_q != {OVF_WIDTH{1'b1}}) begin
        ovf_q <= ovf_q + OVF_WIDTH'(1);
      end
    end
  end

  // Readout register stage: channel 0 goes straight to the output, the rest shift down on acceptance
  always_ff @(posedge CLK) begin
    if (RESET) begin
      snap    <= '0;
      rd_vld  <= 1'b0;
      rd_data <= '0;
      rd_chan <= '0;
      rd_last <= 1'b0;
    end else begin
      case (state)
        LATCH: begin
          snap    <= CNT_IN >> CNT_WIDTH;
          rd_vld  <= 1'b1;
          rd_data <= CNT_IN[CNT_WIDTH-1:0];
          rd_chan <= '0;
`ifdef FRAME_CNT_SCHED_SUM_EN
          rd_last <= 1'b0;
`else
          rd_last <= (CHANNELS == 1);
`endif
        end
        SEND: begin
          if (acc) begin
            if (rd_last) begin
              rd_vld  <= 1'b0;
              rd_last <= 1'b0;
            end else begin
              snap    <= snap >> CNT_WIDTH;
              rd_chan <= nxt_chan;
`ifdef FRAME_CNT_SCHED_SUM_EN
              rd_data <= (rd_chan == LAST_CH) ? sat_add(sum_q, rd_data) : snap[CNT_WIDTH-1:0];
              rd_last <= (nxt_chan == SUM_CH);
`else
              rd_data <= snap[CNT_WIDTH-1:0];
              rd_last <= (nxt_chan == LAST_CH);
`endif
            end
          end
        end
        default: rd_vld <= 1'b0;
      endcase
    end
  end

`ifdef FRAME_CNT_SCHED_SUM_EN
  always_ff @(posedge CLK) begin
    if (RESET || state == LATCH) begin
      sum_q <= '0;
    end else if (state == SEND && acc && rd_chan != SUM_CH) begin
      sum_q <= sat_add(sum_q, rd_data);
    end
  end
`endif

  assign CNT_RST     = {CHANNELS{(state == LATCH) && !RESET}};
  assign RD_DATA     = rd_data;
  assign RD_CHAN     = rd_chan;
  assign RD_LAST     = rd_last;
  assign RD_VLD      = rd_vld;
  assign BUSY        = (state != IDLE);
  assign DONE        = (state == FIN);
  assign OVERRUN_CNT = ovf_q;

endmodule

// File: tb/tb_frame_cnt_sched.sv
// Scoreboard bench for frame_cnt_sched: a transaction-level model predicts per-cycle control outputs and the readout word stream.
module tb_frame_cnt_sched;

  localparam int CH  = 4;
  localparam int CW  = 8;
  localparam int PW  = 8;
  localparam int OW  = 3;
  localparam int CHW = $clog2(CH) + 1;
`ifdef FRAME_CNT_SCHED_SUM_EN
  localparam int NW = CH + 1;
`else
  localparam int NW = CH;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sw_req = 1'b0;
  logic [PW-1:0]     period = '0;
  logic [CH*CW-1:0]  cnt_in = '0;
  logic [CH-1:0]     cnt_rst;
  logic [CW-1:0]     rd_data;
  logic [CHW-1:0]    rd_chan;
  logic              rd_last;
  logic              rd_vld;
  logic              rd_rdy = 1'b0;
  logic              busy;
  logic              done;
  logic [OW-1:0]     ovf;

  frame_cnt_sched #(.CHANNELS(CH), .CNT_WIDTH(CW), .PERIOD_WIDTH(PW), .OVF_WIDTH(OW)) dut (
    .CLK(clk), .RESET(rst), .SW_REQ(sw_req), .PERIOD(period), .CNT_IN(cnt_in),
    .CNT_RST(cnt_rst), .RD_DATA(rd_data), .RD_CHAN(rd_chan), .RD_LAST(rd_last),
    .RD_VLD(rd_vld), .RD_DST_RDY(rd_rdy), .BUSY(busy), .DONE(done), .OVERRUN_CNT(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0]  data;
    logic [CHW-1:0] chan;
    logic           last;
  } word_t;

  typedef struct packed {
    logic          crst;
    logic          done;
    logic          busy;
    logic          vld;
    logic          zero;
    logic [OW-1:0] ovf;
  } cyc_t;

  word_t wq[$];
  cyc_t  cq[$];
  int    checks = 0;
  int    errors = 0;

  localparam int P_IDLE = 0, P_LATCH = 1, P_SEND = 2, P_FIN = 3;
  int m_ph = P_IDLE;
  int m_left = 0;
  int m_timer = 0;
  bit m_pend = 1'b0;
  int m_ovf = 0;
  bit m_rst_prev = 1'b0;
  int snapshots = 0;

  function automatic void check(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", nm, act, req, $time);
    end
  endfunction

  // One clock cycle: drive inputs just after the edge and advance the model by the rules of this cycle
  task automatic cycle(input bit s, input int per, input logic [CH*CW-1:0] c,
                       input bit r, input bit rs, input bit chk);
    cyc_t   e;
    word_t  w;
    bit     req;
    int     ph;
    longint sum;
    longint cmax;
    @(posedge clk);
    #1;
    sw_req = s;
    period = per[PW-1:0];
    cnt_in = c;
    rd_rdy = r;
    rst    = rs;
    ph     = m_ph;
    if (chk) begin
      e.crst = (ph == P_LATCH) && !rs;
      e.done = (ph == P_FIN);
      e.busy = (ph != P_IDLE);
      e.vld  = (ph == P_SEND);
      e.zero = m_rst_prev;
      e.ovf  = OW'(m_ovf);
      cq.push_back(e);
    end
    if (rs) begin
      wq.delete();
      m_ph = P_IDLE;
      m_timer = 0;
      m_pend = 1'b0;
      m_ovf = 0;
      m_rst_prev = 1'b1;
      return;
    end
    m_rst_prev = 1'b0;
    req = s || (per != 0 && m_timer >= per - 1);
    if (ph == P_LATCH) begin
      snapshots++;
      sum = 0;
      cmax = (longint'(1) << CW) - 1;
      for (int i = 0; i < CH; i++) begin
        w.data = c[i*CW +: CW];
        w.chan = CHW'(i);
        w.last = (NW == CH) && (i == CH - 1);
        sum += longint'(w.data);
        wq.push_back(w);
      end
      if (NW > CH) begin
        w.data = CW'((sum > cmax) ? cmax : sum);
        w.chan = CHW'(CH);
        w.last = 1'b1;
        wq.push_back(w);
      end
    end
    if (per == 0 || m_timer >= per - 1) m_timer = 0;
    else m_timer++;
    if (ph == P_IDLE) begin
      if (req || m_pend) m_ph = P_LATCH;
      m_pend = 1'b0;
    end else begin
      if (req) begin
        if (!m_pend) m_pend = 1'b1;
        else if (m_ovf < (1 << OW) - 1) m_ovf++;
      end
      if (ph == P_LATCH) begin
        m_ph = P_SEND;
        m_left = NW;
      end else if (ph == P_SEND) begin
        if (r) begin
          m_left--;
          if (m_left == 0) m_ph = P_FIN;
        end
      end else begin
        m_ph = P_IDLE;
      end
    end
  endtask

  // Monitor: per-cycle control checks plus word scoreboard on every presented word
  initial begin
    cyc_t  e;
    word_t w;
    forever begin
      @(negedge clk);
      if (cq.size() > 0) begin
        e = cq.pop_front();
        check("cnt_rst", cnt_rst, e.crst ? {CH{1'b1}} : '0);
        check("done", done, e.done);
        check("busy", busy, e.busy);
        check("rd_vld", rd_vld, e.vld);
        check("overrun_cnt", ovf, e.ovf);
        if (e.zero) begin
          check("reset_rd_data", rd_data, 0);
          check("reset_rd_chan", rd_chan, 0);
          check("reset_rd_last", rd_last, 0);
        end
      end
      if (!rst && rd_vld === 1'b1) begin
        if (wq.size() == 0) begin
          check("word_unexpected_chan", rd_chan, -1);
        end else begin
          w = wq[0];
          check("rd_data", rd_data, w.data);
          check("rd_chan", rd_chan, w.chan);
          check("rd_last", rd_last, w.last);
          if (rd_rdy) void'(wq.pop_front());
        end
      end
    end
  end

  initial begin
    logic [CH*CW-1:0] c;
    int per;
    cycle(0, 0, '0, 0, 1, 0);
    cycle(0, 0, '0, 0, 1, 1);
    cycle(0, 0, '0, 1, 1, 1);
    repeat (6) cycle(0, 0, '0, 1, 0, 1);

    c = {8'd40, 8'd30, 8'd20, 8'd10};
    cycle(1, 0, c, 1, 0, 1);
    repeat (8) cycle(0, 0, c, 1, 0, 1);

    c = {8'd200, 8'd100, 8'd50, 8'd10};
    cycle(1, 0, c, 1, 0, 1);
    repeat (9) cycle(0, 0, c, 1, 0, 1);

    c = {8'd4, 8'd3, 8'd20, 8'd1};
    cycle(1, 0, c, 1, 0, 1);
    cycle(0, 0, c, 1, 0, 1);
    cycle(0, 0, c, 1, 0, 1);
    repeat (5) cycle(0, 0, c, 0, 0, 1);
    repeat (8) cycle(0, 0, c, 1, 0, 1);

    repeat (200) cycle(0, 20, CH*CW'($urandom), 1, 0, 1);
    repeat (10) cycle(0, 0, '0, 1, 0, 1);

    cycle(1, 0, CH*CW'($urandom), 1, 0, 1);
    repeat (3) cycle(1, 0, CH*CW'($urandom), 0, 0, 1);
    repeat (10) cycle(0, 0, CH*CW'($urandom), 1, 0, 1);
    cycle(1, 0, CH*CW'($urandom), 0, 0, 1);
    repeat (12) cycle(1, 0, CH*CW'($urandom), 0, 0, 1);
    repeat (25) cycle(0, 0, CH*CW'($urandom), 1, 0, 1);

    c = {8'd77, 8'd66, 8'd55, 8'd44};
    cycle(1, 0, c, 1, 0, 1);
    cycle(0, 0, c, 1, 0, 1);
    cycle(0, 0, c, 1, 0, 1);
    cycle(0, 0, c, 1, 0, 1);
    cycle(0, 0, c, 0, 1, 1);
    repeat (3) cycle(0, 0, c, 1, 0, 1);
    cycle(1, 0, c, 1, 0, 1);
    repeat (9) cycle(0, 0, c, 1, 0, 1);

    per = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) per = ($urandom % 3 == 0) ? 0 : int'($urandom_range(1, 40));
      cycle($urandom % 8 == 0, per, CH*CW'($urandom), $urandom % 4 != 0,
            $urandom % 500 == 0, 1);
    end

    repeat (40) cycle(0, 0, '0, 1, 0, 1);
    @(negedge clk);
    #1;
    check("words_drained", wq.size(), 0);
    check("cycles_drained", cq.size(), 0);
    check("snapshots_seen", snapshots > 20, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
